// File: rtl/ccu_decrypt_if.sv
// Nibble-serial bus shared by the Mini-AES decrypt core and whatever feeds it.
// The master drives ciphertext/key nibbles; the slave returns plaintext nibbles.
interface ccu_decrypt_if;
    logic       load;
    logic [3:0] data_in;
    logic [3:0] key_in;
    logic       busy;
    logic       out_valid;
    logic [3:0] data_out;

    modport master (output load, data_in, key_in, input busy, out_valid, data_out);
    modport slave  (input load, data_in, key_in, output busy, out_valid, data_out);
endinterface

// File: rtl/ccu_decrypt.sv
// Nibble-serial Mini-AES inverse cipher: four ciphertext/key nibbles in,
// key expansion plus two inverse rounds on one edge each, four plaintext nibbles out.
module ccu_decrypt #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    ccu_decrypt_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, KEYX, R2, R1, FIN, OUT} state_t;

    // Forward and inverse nibble S-boxes; entry n sits at bits [4n+3:4n].
    localparam logic [63:0] SBOX     = 64'h7095_C6A3_8BF2_1D4E;
    localparam logic [63:0] INV_SBOX = 64'h502B_69D7_FAC1_843E;

    state_t      state, state_next;
    logic [1:0]  cnt, cnt_next;
    logic [15:0] blk, blk_next;
    logic [15:0] key, key_next;
    logic [15:0] rk1, rk1_next;
    logic [15:0] rk2, rk2_next;
    logic [15:0] shreg, shreg_next;
    logic        oval, oval_next;

    function automatic logic [3:0] sub_nib(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [15:0] inv_sub(input logic [15:0] s);
        return {INV_SBOX[{s[15:12], 2'b00} +: 4], INV_SBOX[{s[11:8], 2'b00} +: 4],
                INV_SBOX[{s[7:4], 2'b00} +: 4],   INV_SBOX[{s[3:0], 2'b00} +: 4]};
    endfunction

    function automatic logic [15:0] shift_rows(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    // Multiply by x in GF(2^4) with x^4 = x + 1.
    function automatic logic [3:0] mul2(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
    endfunction

    function automatic logic [7:0] mix_col(input logic [3:0] a, input logic [3:0] b);
        return {mul2(a) ^ a ^ mul2(b), mul2(a) ^ mul2(b) ^ b};
    endfunction

    function automatic logic [15:0] mix(input logic [15:0] s);
        return {mix_col(s[15:12], s[11:8]), mix_col(s[7:4], s[3:0])};
    endfunction

    // Returns {K1, K2}; K0 is the loaded key itself.
    function automatic logic [31:0] expand_key(input logic [15:0] k);
        logic [3:0] w4, w5, w6, w7, w8, w9, w10, w11;
        w4  = k[15:12] ^ sub_nib(k[3:0]) ^ 4'h1;
        w5  = k[11:8] ^ w4;
        w6  = k[7:4] ^ w5;
        w7  = k[3:0] ^ w6;
        w8  = w4 ^ sub_nib(w7) ^ 4'h2;
        w9  = w5 ^ w8;
        w10 = w6 ^ w9;
        w11 = w7 ^ w10;
        return {w4, w5, w6, w7, w8, w9, w10, w11};
    endfunction

    function automatic logic [15:0] shift_in(input logic [15:0] r, input logic [3:0] nib);
        return MSB_FIRST ? {r[11:0], nib} : {nib, r[15:4]};
    endfunction

    function automatic logic [15:0] shift_out(input logic [15:0] r);
        return MSB_FIRST ? {r[11:0], 4'h0} : {4'h0, r[15:4]};
    endfunction

    // State and datapath registers; reset discards any block in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
            blk   <= 16'h0;
            key   <= 16'h0;
            rk1   <= 16'h0;
            rk2   <= 16'h0;
            shreg <= 16'h0;
            oval  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            blk   <= blk_next;
            key   <= key_next;
            rk1   <= rk1_next;
            rk2   <= rk2_next;
            shreg <= shreg_next;
            oval  <= oval_next;
        end
    end

    // Sequencing: collect nibbles, one edge per cipher step, then stream the result.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        blk_next   = blk;
        key_next   = key;
        rk1_next   = rk1;
        rk2_next   = rk2;
        shreg_next = shreg;
        oval_next  = oval;
        case (state)
            IDLE, LOAD: begin
                if (bus.load) begin
                    blk_next = shift_in(blk, bus.data_in);
                    key_next = shift_in(key, bus.key_in);
                    if (cnt == 2'd3) begin
                        cnt_next   = 2'd0;
                        state_next = KEYX;
                    end else begin
                        cnt_next   = cnt + 2'd1;
                        state_next = LOAD;
                    end
                end else if (state == LOAD) begin
                    cnt_next   = 2'd0;
                    state_next = IDLE;
                end
            end
            KEYX: begin
                {rk1_next, rk2_next} = expand_key(key);
                state_next = R2;
            end
            R2: begin
                blk_next   = inv_sub(shift_rows(blk ^ rk2));
                state_next = R1;
            end
            R1: begin
                blk_next   = inv_sub(shift_rows(mix(blk ^ rk1)));
                state_next = FIN;
            end
            FIN: begin
                shreg_next = blk ^ key;
                oval_next  = 1'b1;
                cnt_next   = 2'd0;
                state_next = OUT;
            end
            OUT: begin
                if (cnt == 2'd3) begin
                    shreg_next = 16'h0;
                    oval_next  = 1'b0;
                    cnt_next   = 2'd0;
                    state_next = IDLE;
                end else begin
                    shreg_next = shift_out(shreg);
                    cnt_next   = cnt + 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy      = state inside {KEYX, R2, R1, FIN, OUT};
    assign bus.out_valid = oval;
    assign bus.data_out  = oval ? (MSB_FIRST ? shreg[15:12] : shreg[3:0]) : 4'h0;

endmodule
